kalman_scalar_mc: RTL and testbench

//  Time-multiplexed, multi-channel scalar Kalman filter core with a constant-state model.

---
 rtl/kalman_pkg.sv | 36 +++
 rtl/kalman_gain_div.sv | 72 +++++++
 rtl/kalman_scalar_mc.sv | 180 ++++++++++++++++++
 tb/tb_kalman_scalar_mc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kalman_pkg.sv
// Shared definitions for the multi-channel scalar Kalman core.
//   kstate_t  : sequencing states of the core FSM
//   gain_one  : 2^frac, the gain value representing 1.0 in UQ1.frac
//   sat_u     : clamp an unsigned value to w bits
//   sat_s     : clamp a signed value to the w-bit two's-complement range
package kalman_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREDICT,
    ST_DIVIDE,
    ST_UPDATE,
    ST_OUTPUT
  } kstate_t;

  function automatic int gain_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic logic [31:0] sat_u(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic signed [31:0] sat_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/kalman_gain_div.sv
// Restoring divider producing the Kalman gain K = floor(num * 2^(Q_W-1) / den).
// The numerator never exceeds the denominator, so the integer part of the
// quotient is a single bit; Q_W iterations yield one quotient bit each, MSB first.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands (one-cycle strobe)
//   num      : numerator (predicted variance), NUM_W bits
//   den      : denominator (variance + measurement noise), DEN_W bits
//   done     : one-cycle pulse once quot is valid
//   quot     : quotient, held until the next start; 0 when den was 0
module kalman_gain_div #(
  parameter int NUM_W = 8,
  parameter int DEN_W = 9,
  parameter int Q_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [DEN_W:0]   rem;
  logic [DEN_W:0]   trial;
  logic [DEN_W-1:0] den_r;
  logic [Q_W-1:0]   q_r;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             first;
  logic             ge;

  // The first step tests the integer bit, so the remainder is not shifted.
  // Afterwards rem < den, so the left shift cannot lose a bit.
  assign trial = first ? rem : {rem[DEN_W-1:0], 1'b0};
  assign ge    = trial >= {1'b0, den_r};
  assign quot  = (den_r == '0) ? '0 : q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      den_r <= '0;
      q_r   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      first <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= (DEN_W + 1)'(num);
        den_r <= den;
        q_r   <= '0;
        cnt   <= CNT_W'(Q_W);
        busy  <= 1'b1;
        first <= 1'b1;
      end else if (busy) begin
        rem   <= ge ? (trial - {1'b0, den_r}) : trial;
        q_r   <= {q_r[Q_W-2:0], ge};
        first <= 1'b0;
        cnt   <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kalman_scalar_mc.sv
// Time-multiplexed multi-channel scalar Kalman filter (constant-state model).
// One measurement per transaction: predict, gain divide, update, then present
// estimate, variance and gain until the consumer takes them.
//   clk, rst                  : clock, synchronous active-high reset
//   meas_valid/meas_ready     : measurement handshake
//   meas_ch, meas_data        : channel and signed measurement z
//   q_var, r_var              : unsigned process / measurement noise
//   out_valid/out_ready       : result handshake
//   out_ch, out_est, out_var  : result channel, signed estimate, unsigned variance
//   out_gain                  : gain K in UQ1.FRAC
//   err_ch                    : one-cycle pulse for a dropped out-of-range channel
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and its payload stable until that edge, and ready
// never depends combinationally on the same interface's valid.
module kalman_scalar_mc
  import kalman_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FRAC     = 4,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_valid,
  output logic             meas_ready,
  input  logic [CH_W-1:0]  meas_ch,
  input  logic [WIDTH-1:0] meas_data,
  input  logic [WIDTH-1:0] q_var,
  input  logic [WIDTH-1:0] r_var,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_est,
  output logic [WIDTH-1:0] out_var,
  output logic [FRAC:0]    out_gain,
  output logic             err_ch
);

  // Arrays are sized to the full channel-index space so every index is in range.
  localparam int DEPTH = 1 << CH_W;
  localparam int PW    = WIDTH + FRAC + 3;
  localparam int PU    = WIDTH + FRAC + 1;
  localparam logic [FRAC:0] GAIN_ONE = (FRAC + 1)'(gain_one(FRAC));

  kstate_t state;
  kstate_t state_nxt;

  logic [CH_W-1:0]  ch_r;
  logic [WIDTH-1:0] z_r, q_r, r_r;
  logic             init_r;  // channel already holds an estimate
  logic [WIDTH-1:0] x_pred, p_pred;

  logic [WIDTH-1:0] x_arr [DEPTH];
  logic [WIDTH-1:0] p_arr [DEPTH];
  logic [DEPTH-1:0] init_arr;

  logic             accept, ch_bad;
  logic [WIDTH:0]   p_sum, div_den;
  logic [WIDTH-1:0] p_sat;
  logic             div_done;
  logic [FRAC:0]    div_quot;

  logic signed [WIDTH:0] err_e;
  logic signed [PW-1:0]  corr_prod, x_sum;
  logic [PU-1:0]         var_prod;
  logic [WIDTH-1:0]      x_upd, p_upd;

  assign meas_ready = (state == ST_IDLE) && !rst;
  assign accept     = meas_valid && meas_ready;
  assign ch_bad     = int'(meas_ch) >= CHANNELS;

  // Predict: variance grows by Q and saturates at full scale.
  assign p_sum   = {1'b0, p_arr[ch_r]} + {1'b0, q_r};
  assign p_sat   = WIDTH'(sat_u(32'(p_sum), WIDTH));
  assign div_den = {1'b0, p_sat} + {1'b0, r_r};

  kalman_gain_div #(
    .NUM_W (WIDTH),
    .DEN_W (WIDTH + 1),
    .Q_W   (FRAC + 1)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (state == ST_PREDICT),
    .num   (p_sat),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Update: the correction is floored by the arithmetic shift; the result lies
  // between x' and z, the clamp only guards against parameter misuse.
  assign err_e     = $signed({z_r[WIDTH-1], z_r}) - $signed({x_pred[WIDTH-1], x_pred});
  assign corr_prod = PW'($signed({1'b0, div_quot})) * PW'(err_e);
  assign x_sum     = PW'($signed(x_pred)) + (corr_prod >>> FRAC);
  assign x_upd     = WIDTH'(sat_s(32'(x_sum), WIDTH));
  assign var_prod  = PU'(GAIN_ONE - div_quot) * PU'(p_pred);
  assign p_upd     = WIDTH'(sat_u(32'(var_prod >> FRAC), WIDTH));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (accept && !ch_bad) state_nxt = ST_PREDICT;
      ST_PREDICT: state_nxt = ST_DIVIDE;
      ST_DIVIDE:  if (div_done) state_nxt = ST_UPDATE;
      ST_UPDATE:  state_nxt = ST_OUTPUT;
      ST_OUTPUT:  if (out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch_r      <= '0;
      z_r       <= '0;
      q_r       <= '0;
      r_r       <= '0;
      init_r    <= 1'b0;
      x_pred    <= '0;
      p_pred    <= '0;
      init_arr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_arr[i] <= '0;
        p_arr[i] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_est   <= '0;
      out_var   <= '0;
      out_gain  <= '0;
      err_ch    <= 1'b0;
    end else begin
      state  <= state_nxt;
      err_ch <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (ch_bad) begin
              err_ch <= 1'b1;
            end else begin
              ch_r   <= meas_ch;
              z_r    <= meas_data;
              q_r    <= q_var;
              r_r    <= r_var;
              init_r <= init_arr[meas_ch];
            end
          end
        end
        ST_PREDICT: begin
          x_pred <= x_arr[ch_r];
          p_pred <= p_sat;
        end
        ST_UPDATE: begin
          init_arr[ch_r] <= 1'b1;
          out_valid      <= 1'b1;
          out_ch         <= ch_r;
          if (init_r) begin
            x_arr[ch_r] <= x_upd;
            p_arr[ch_r] <= p_upd;
            out_est     <= x_upd;
            out_var     <= p_upd;
            out_gain    <= div_quot;
          end else begin
            // First sample seeds the channel: x = z, P = R, K reported as 1.0.
            x_arr[ch_r] <= z_r;
            p_arr[ch_r] <= r_r;
            out_est     <= z_r;
            out_var     <= r_r;
            out_gain    <= GAIN_ONE;
          end
        end
        ST_OUTPUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_scalar_mc.sv
// Bench for kalman_scalar_mc (WIDTH=8, FRAC=4): a two-channel instance for the
// filter behaviour and a one-channel instance for the out-of-range channel path.
module tb_kalman_scalar_mc;

  localparam int W = 22;  // {ch, est[7:0], var[7:0], gain[4:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // two-channel instance
  logic       meas_valid = 1'b0;
  logic       meas_ready;
  logic [0:0] meas_ch = '0;
  logic [7:0] meas_data = '0, q_var = '0, r_var = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [0:0] out_ch;
  logic [7:0] out_est, out_var;
  logic [4:0] out_gain;
  logic       err_ch;

  // one-channel instance
  logic       meas_valid_1 = 1'b0;
  logic       meas_ready_1;
  logic [0:0] meas_ch_1 = '0;
  logic [7:0] meas_data_1 = '0, q_var_1 = '0, r_var_1 = '0;
  logic       out_valid_1;
  logic       out_ready_1 = 1'b1;
  logic [0:0] out_ch_1;
  logic [7:0] out_est_1, out_var_1;
  logic [4:0] out_gain_1;
  logic       err_ch_1;

  kalman_scalar_mc #(.WIDTH(8), .FRAC(4), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_ch(meas_ch),
    .meas_data(meas_data), .q_var(q_var), .r_var(r_var),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_est(out_est), .out_var(out_var), .out_gain(out_gain), .err_ch(err_ch)
  );

  kalman_scalar_mc #(.WIDTH(8), .FRAC(4), .CHANNELS(1)) dut_1ch (
    .clk(clk), .rst(rst),
    .meas_valid(meas_valid_1), .meas_ready(meas_ready_1), .meas_ch(meas_ch_1),
    .meas_data(meas_data_1), .q_var(q_var_1), .r_var(r_var_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_ch(out_ch_1),
    .out_est(out_est_1), .out_var(out_var_1), .out_gain(out_gain_1), .err_ch(err_ch_1)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int m_x[2];
  int m_p[2];
  bit m_init[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0;
      m_p[i] = 0;
      m_init[i] = 1'b0;
    end
  endtask

  // Reference filter in plain integer arithmetic.
  task automatic model_push(input int ch, input logic [7:0] zb, input logic [7:0] qb,
                            input logic [7:0] rb);
    int z, q, r, x, p, pp, d, k, e;
    logic [0:0] chb;
    z = int'($signed(zb));
    q = int'(qb);
    r = int'(rb);
    if (!m_init[ch]) begin
      x = z;
      p = r;
      k = 16;
    end else begin
      pp = m_p[ch] + q;
      if (pp > 255) pp = 255;
      d = pp + r;
      k = (d == 0) ? 0 : (pp * 16) / d;
      e = z - m_x[ch];
      x = m_x[ch] + ((k * e) >>> 4);
      p = ((16 - k) * pp) / 16;
    end
    m_x[ch] = x;
    m_p[ch] = p;
    m_init[ch] = 1'b1;
    chb = ch[0];
    exp_q.push_back({chb, x[7:0], p[7:0], k[4:0]});
  endtask

  // driver: offer one measurement, then scramble the inputs after the accept edge
  task automatic send(input int ch, input logic [7:0] z, input logic [7:0] q, input logic [7:0] r);
    int guard;
    guard = 0;
    while (!meas_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_send", meas_ready, 1);
    meas_valid = 1'b1;
    meas_ch    = ch[0];
    meas_data  = z;
    q_var      = q;
    r_var      = r;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    meas_ch    = 1'($urandom);
    meas_data  = 8'($urandom);
    q_var      = 8'($urandom);
    r_var      = 8'($urandom);
    chk("ready_low_busy", meas_ready, 0);
    model_push(ch, z, q, r);
  endtask

  // consumer: wait for the result, compare, optionally stall for 'hold' cycles
  task automatic collect(input int hold);
    int lat;
    logic [W-1:0] e;
    logic [W-1:0] snap;
    out_ready = (hold == 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 8);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid, 1);
      chk("out_ch", out_ch, e[21]);
      chk("out_est", out_est, e[20:13]);
      chk("out_var", out_var, e[12:5]);
      chk("out_gain", out_gain, e[4:0]);
    end
    if (hold > 0) begin
      snap = {out_ch, out_est, out_var, out_gain};
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_stable", {out_valid, out_ch, out_est, out_var, out_gain}, {1'b1, snap});
        chk("bp_ready_low", meas_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("handshake_clears_valid", out_valid, 0);
    chk("ready_after_handshake", meas_ready, 1);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    model_clear();

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_all", {out_ch, out_est, out_var, out_gain, err_ch}, 0);
    chk("rst_meas_ready", meas_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_meas_ready", meas_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // init, then update on channel 0
    send(0, 8'h20, 8'h00, 8'h10); collect(0);
    send(0, 8'h40, 8'h00, 8'h10); collect(0);
    // channel isolation
    send(1, 8'hF0, 8'h00, 8'h20); collect(0);
    send(0, 8'h30, 8'h00, 8'h08); collect(0);
    // variance saturation, then zero denominator
    send(0, 8'h50, 8'hFF, 8'h00); collect(0);
    send(0, 8'h10, 8'h00, 8'h00); collect(0);
    // channel 1 crossing zero, then a negative correction that floors
    send(1, 8'h10, 8'h00, 8'h20); collect(0);
    send(1, 8'hFD, 8'h00, 8'h30); collect(10);

    // reset while the divider is running
    send(0, 8'h11, 8'h05, 8'h05);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs_zero", {out_valid, out_ch, out_est, out_var, out_gain, err_ch}, 0);
    chk("abort_ready_in_rst", meas_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    send(0, 8'h7F, 8'h03, 8'h22); collect(0);
    send(1, 8'h80, 8'h10, 8'h01); collect(1);

    // randomised traffic
    for (int t = 0; t < 16; t++) begin
      send(int'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 64)), 8'($urandom_range(0, 96)));
      collect(int'($urandom_range(0, 2)));
    end

    // out-of-range channel on the single-channel instance
    chk("err_idle_ready", meas_ready_1, 1);
    meas_valid_1 = 1'b1;
    meas_ch_1    = 1'b1;
    meas_data_1  = 8'h33;
    q_var_1      = 8'h01;
    r_var_1      = 8'h10;
    @(posedge clk); #1;
    meas_valid_1 = 1'b0;
    chk("err_pulse", err_ch_1, 1);
    chk("err_stays_idle", meas_ready_1, 1);
    @(posedge clk); #1;
    chk("err_one_cycle", err_ch_1, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid_1) seen++;
    end
    chk("err_no_output", seen, 0);
    chk("err_other_inst_quiet", err_ch, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
